// File: rtl/dpll_pkg.sv
// Types and clamp helpers shared by the DPLL loop filter and its lock detector.
`ifndef N_BIT
`define N_BIT 8
`endif

package dpll_pkg;
   localparam int N_BIT = `N_BIT;

   typedef enum logic [1:0] {S_IDLE, S_ERR, S_INT, S_OUT} state_t;

   typedef struct packed {
      logic             first_second;
      logic [N_BIT-1:0] diff_1;
      logic [N_BIT-1:0] diff_2;
      logic             timeout;
   } pfd_meas_t;

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Saturate to the range of a w-bit two's complement value.
   function automatic longint sat_signed(input longint v, input int w);
      longint lim;
      lim = 64'sd1 <<< (w - 1);
      return clamp(v, -lim, lim - 1);
   endfunction
endpackage

// File: rtl/config.sv
// Shared DPLL build configuration: pfd counter width.
`ifndef N_BIT
`define N_BIT 8
`endif

// File: rtl/dpll_lock_detect.sv
// Lock detector: counts consecutive small, non-timeout phase errors.
module dpll_lock_detect
   import dpll_pkg::*;
#(
   parameter int EW       = N_BIT + 1,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CNT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic signed [EW-1:0] i_err,
   input  logic                 i_timeout,
   output logic                 o_locked
);
   localparam int CW = $clog2(LOCK_CNT + 1);

   logic [CW-1:0] r_cnt;
   logic          r_locked;
   logic [EW:0]   w_ext;
   logic [EW:0]   w_abs;
   logic          w_in_tol;

   assign w_ext    = {i_err[EW-1], i_err};
   assign w_abs    = i_err[EW-1] ? (~w_ext + 1'b1) : w_ext;
   assign w_in_tol = !i_timeout && (w_abs <= (EW+1)'(LOCK_TOL));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_locked <= 1'b0;
      end else if (i_en) begin
         if (w_in_tol) begin
            if (r_cnt < CW'(LOCK_CNT)) r_cnt <= r_cnt + 1'b1;
            r_locked <= (r_cnt >= CW'(LOCK_CNT - 1));
         end else begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
         end
      end
   end

   assign o_locked = r_locked;
endmodule

// File: rtl/dpll_loop_filter.sv
// DPLL proportional-integral loop filter: pfd measurement in, clamped DCO control word out.
module dpll_loop_filter
   import dpll_pkg::*;
#(
   parameter int     CTRL_W    = 16,
   parameter int     KP_SHIFT  = 2,
   parameter int     KI_SHIFT  = 4,
   parameter longint CTRL_INIT = 1000,
   parameter longint CTRL_MIN  = 0,
   parameter longint CTRL_MAX  = (64'sd1 <<< CTRL_W) - 1,
   parameter int     LOCK_TOL  = 2,
   parameter int     LOCK_CNT  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ready,
   input  logic              i_first_second,
   input  logic [N_BIT-1:0]  i_diff_1,
   input  logic [N_BIT-1:0]  i_diff_2,
   input  logic              i_timeout,
   output logic [CTRL_W-1:0] o_ctrl_word,
   output logic              o_ctrl_valid,
   output logic              o_locked,
   output logic              o_overrun
);
   localparam int EW = N_BIT + 1;
   localparam int IW = CTRL_W + KI_SHIFT + 1;

   state_t                r_state;
   pfd_meas_t             r_cap, r_pend, w_meas;
   logic                  r_pend_vld;
   logic signed [EW-1:0]  r_err, w_err;
   logic signed [IW-1:0]  r_integ;
   logic [CTRL_W-1:0]     r_ctrl;
   logic                  r_valid, r_overrun;
   logic [N_BIT-1:0]      w_mag;
   logic                  w_pop, w_direct, w_push, w_drop;
   longint                w_integ_n, w_sum;

   assign w_meas = {i_first_second, i_diff_1, i_diff_2, i_timeout};
   assign w_mag  = r_cap.timeout ? '1 : (r_cap.first_second ? r_cap.diff_1 : r_cap.diff_2);
   assign w_err  = r_cap.first_second ? $signed({1'b0, w_mag}) : -$signed({1'b0, w_mag});

   // Pending slot frees whenever the FSM is about to start a new sample, so a
   // ready arriving in that same cycle can still be parked there.
   assign w_pop    = r_pend_vld && (r_state == S_IDLE || r_state == S_OUT);
   assign w_direct = i_ready && (r_state == S_IDLE) && !r_pend_vld;
   assign w_push   = i_ready && !w_direct && (!r_pend_vld || w_pop);
   assign w_drop   = i_ready && !w_direct && !w_push;

   always_comb begin
      w_integ_n = sat_signed(longint'(r_integ) + longint'(r_err), IW);
      w_sum     = CTRL_INIT + (w_integ_n >>> KI_SHIFT) + (longint'(r_err) <<< KP_SHIFT);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_pend_vld <= 1'b0;
         r_integ    <= '0;
         r_ctrl     <= CTRL_W'(CTRL_INIT);
         r_valid    <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_valid    <= (r_state == S_INT);
         r_pend_vld <= w_push || (r_pend_vld && !w_pop);
         if (w_drop) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: if (w_pop || w_direct) r_state <= S_ERR;
            S_ERR:  r_state <= S_INT;
            S_INT: begin
               r_state <= S_OUT;
               r_integ <= IW'(w_integ_n);
               r_ctrl  <= CTRL_W'(clamp(w_sum, CTRL_MIN, CTRL_MAX));
            end
            S_OUT:   r_state <= w_pop ? S_ERR : S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_direct)   r_cap <= w_meas;
      else if (w_pop) r_cap <= r_pend;
      if (w_push) r_pend <= w_meas;
      if (r_state == S_ERR) r_err <= w_err;
   end

   dpll_lock_detect #(
      .EW       (EW),
      .LOCK_TOL (LOCK_TOL),
      .LOCK_CNT (LOCK_CNT)
   ) u_lock (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (r_state == S_INT),
      .i_err     (r_err),
      .i_timeout (r_cap.timeout),
      .o_locked  (o_locked)
   );

   assign o_ctrl_word  = r_ctrl;
   assign o_ctrl_valid = r_valid;
   assign o_overrun    = r_overrun | w_drop;
endmodule

// File: tb/tb_dpll_loop_filter.sv
// Directed bench for dpll_loop_filter with a scoreboard queue of expected control words.
`timescale 1ns/1ps
module tb_dpll_loop_filter;
   import dpll_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ready = 1'b0, fs = 1'b0, to = 1'b0;
   logic [N_BIT-1:0] d1 = '0, d2 = '0;
   logic [15:0]      cw_a, cw_b;
   logic             vld_a, vld_b, lk_a, lk_b, ov_a, ov_b;

   int total = 0;
   int bad = 0;
   int vld_cnt = 0;
   int base;
   logic prev_v = 1'b0;

   typedef struct {
      longint ctrl_a;
      longint ctrl_b;
      logic   lk;
   } exp_t;
   exp_t   q[$];
   exp_t   m_e;
   longint m_integ;
   int     m_cnt;
   logic   m_lk;

   always #5 clk = ~clk;

   dpll_loop_filter dut_a (
      .i_clk(clk), .i_rst(rst), .i_ready(ready), .i_first_second(fs),
      .i_diff_1(d1), .i_diff_2(d2), .i_timeout(to),
      .o_ctrl_word(cw_a), .o_ctrl_valid(vld_a), .o_locked(lk_a), .o_overrun(ov_a));

   dpll_loop_filter #(.CTRL_MAX(1500)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_ready(ready), .i_first_second(fs),
      .i_diff_1(d1), .i_diff_2(d2), .i_timeout(to),
      .o_ctrl_word(cw_b), .o_ctrl_valid(vld_b), .o_locked(lk_b), .o_overrun(ov_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      q.delete();
      m_integ = 0;
      m_cnt   = 0;
      m_lk    = 1'b0;
   endtask

   task automatic model(input logic f, input int d, input logic t);
      longint mag, e, sum;
      exp_t   x;
      mag = t ? ((64'sd1 <<< N_BIT) - 1) : longint'(d);
      e   = f ? mag : -mag;
      m_integ = m_integ + e;
      if (m_integ > 1048575)  m_integ = 1048575;
      if (m_integ < -1048576) m_integ = -1048576;
      sum = 1000 + (m_integ >>> 4) + e * 4;
      x.ctrl_a = (sum < 0) ? 0 : (sum > 65535) ? 65535 : sum;
      x.ctrl_b = (sum < 0) ? 0 : (sum > 1500) ? 1500 : sum;
      if (!t && mag <= 2) begin
         if (m_cnt < 4) m_cnt++;
         m_lk = (m_cnt >= 4);
      end else begin
         m_cnt = 0;
         m_lk  = 1'b0;
      end
      x.lk = m_lk;
      q.push_back(x);
   endtask

   task automatic drive(input logic f, input int d, input logic t, input bit exp_it);
      fs    = f;
      d1    = f ? N_BIT'(d) : N_BIT'(8'hAA);
      d2    = f ? N_BIT'(8'h55) : N_BIT'(d);
      to    = t;
      ready = 1'b1;
      if (exp_it) model(f, d, t);
   endtask

   task automatic send(input logic f, input int d, input logic t);
      @(posedge clk); #1;
      drive(f, d, t, 1'b1);
      @(posedge clk); #1;
      ready = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("drain", q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && vld_a) begin
         vld_cnt++;
         chk("valid_b_align", vld_b, 1);
         chk("valid_single", prev_v, 0);
         if (q.size() == 0) chk("unexpected_valid", q.size(), 1);
         else begin
            m_e = q.pop_front();
            chk("ctrl_a", cw_a, m_e.ctrl_a[15:0]);
            chk("ctrl_b", cw_b, m_e.ctrl_b[15:0]);
            chk("locked", lk_a, m_e.lk);
         end
      end
      prev_v = vld_a;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ctrl", cw_a, 1000);
      chk("rst_valid", vld_a, 0);
      chk("rst_locked", lk_a, 0);
      chk("rst_overrun", ov_a, 0);

      // positive error, latency 3
      send(1'b1, 16, 1'b0);
      @(negedge clk); chk("lat_c1", vld_a, 0);
      @(negedge clk); chk("lat_c2", vld_a, 0);
      @(negedge clk); chk("lat_c3", vld_a, 1);
      chk("ctrl_1065", cw_a, 1065);
      drain();

      // negative error, integrator accumulates
      do_reset();
      send(1'b0, 16, 1'b0);
      drain();
      chk("ctrl_935", cw_a, 935);
      send(1'b0, 16, 1'b0);
      drain();
      chk("ctrl_934", cw_a, 934);
      repeat (5) @(posedge clk);
      #1;
      chk("ctrl_hold", cw_a, 934);

      // timeout saturation and clamps
      do_reset();
      send(1'b1, 0, 1'b1);
      drain();
      chk("timeout_pos", cw_a, 2035);
      chk("timeout_max_clamp", cw_b, 1500);
      do_reset();
      send(1'b0, 0, 1'b1);
      drain();
      chk("timeout_min_a", cw_a, 0);
      chk("timeout_min_b", cw_b, 0);

      // lock acquisition and loss
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 1, 1'b0);
         drain();
         chk("lock_progress", lk_a, (i == 3) ? 1 : 0);
      end
      send(1'b1, 10, 1'b0);
      drain();
      chk("lock_lost", lk_a, 0);

      // back-to-back ready: third sample is dropped
      do_reset();
      base = vld_cnt;
      @(posedge clk); #1; drive(1'b1, 5, 1'b0, 1'b1);
      @(negedge clk); chk("ov_c0", ov_a, 0);
      @(posedge clk); #1; drive(1'b1, 6, 1'b0, 1'b1);
      @(negedge clk); chk("ov_c1", ov_a, 0);
      @(posedge clk); #1; drive(1'b1, 7, 1'b0, 1'b0);
      @(negedge clk); chk("ov_c2", ov_a, 1);
      @(posedge clk); #1; ready = 1'b0;
      @(negedge clk); chk("burst_v3", vld_a, 1);
      @(negedge clk); chk("burst_v4", vld_a, 0);
      @(negedge clk); chk("burst_v5", vld_a, 0);
      @(negedge clk); chk("burst_v6", vld_a, 1);
      repeat (10) @(negedge clk);
      drain();
      chk("burst_count", vld_cnt - base, 2);
      chk("ov_sticky", ov_a, 1);

      // asynchronous reset while in S_INT
      send(1'b1, 20, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_ctrl", cw_a, 1000);
      chk("midrst_valid", vld_a, 0);
      chk("midrst_locked", lk_a, 0);
      chk("midrst_overrun", ov_a, 0);
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      base = vld_cnt;
      repeat (6) @(negedge clk);
      chk("midrst_no_valid", vld_cnt - base, 0);

      // ready coinciding with S_OUT is parked and processed
      base = vld_cnt;
      send(1'b1, 3, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      drive(1'b0, 4, 1'b0, 1'b1);
      @(posedge clk); #1;
      ready = 1'b0;
      drain();
      chk("sout_count", vld_cnt - base, 2);
      chk("sout_overrun", ov_a, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
